// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// State encodings, state width and default memory-wait timeout.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned PHC_STATE_BIT       = 2;
  localparam int unsigned PHC_MEM_TIMEOUT_DEF = 16;

  typedef enum logic [PHC_STATE_BIT-1:0] {
    PHC_BOOT     = 2'd0,
    PHC_RUN      = 2'd1,
    PHC_MEM_WAIT = 2'd2,
    PHC_HALTED   = 2'd3
  } phc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// clr_i and en_i together restart the count at one.
module phc_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  // Next count: optional clear, then increment unless already all-ones
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (en_i && (base != '1)) begin
      cnt_d = base + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables/clears, halt and memory wait.
// Optional PIPE_HAZARD_PERF_EN adds stall and flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = PHC_MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        dm_busy,
  input  logic        halt_wb,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_stall,
  output logic        ifid_clr,
  output logic        idex_en,
  output logic        idex_clr,
  output logic        exdm_en,
  output logic        exdm_clr,
  output logic        dmwb_en,
  output logic        dmwb_clr,
  output logic        halted,
  output logic        mem_fault
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  phc_state_e state_q;
  phc_state_e state_d;

  logic             fault_q;
  logic             run_q;
  logic             run_busy;
  logic             wait_busy;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;
  logic             fault_hit;

  assign run_q     = (state_q == PHC_RUN);
  assign run_busy  = run_q && !halt_wb && dm_busy;
  assign wait_busy = (state_q == PHC_MEM_WAIT) && dm_busy;
  assign cnt_en    = run_busy || wait_busy;
  assign cnt_clr   = run_busy;

  // Value the wait counter takes at the next edge
  assign cnt_nx    = run_busy ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign fault_hit = cnt_en && (32'(cnt_nx) >= MEM_TIMEOUT);

  phc_sat_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_q)
  );

  // Stage controls and next state from current state and hazards
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_stall = 1'b0;
    ifid_clr   = 1'b0;
    idex_en    = 1'b0;
    idex_clr   = 1'b0;
    exdm_en    = 1'b0;
    exdm_clr   = 1'b0;
    dmwb_en    = 1'b0;
    dmwb_clr   = 1'b0;
    unique case (state_q)
      PHC_BOOT: begin
        state_d = PHC_RUN;
      end
      PHC_RUN: begin
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
        exdm_clr = 1'b1;
        dmwb_clr = 1'b1;
        if (halt_wb) begin
          state_d = PHC_HALTED;
        end else if (dm_busy) begin
          state_d = fault_hit ? PHC_HALTED : PHC_MEM_WAIT;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          idex_en = 1'b1;
          exdm_en = 1'b1;
          dmwb_en = 1'b1;
          if (branch_taken) begin
            ifid_clr = 1'b0;
            idex_clr = 1'b0;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_stall = 1'b1;
            idex_clr   = 1'b0;
          end
        end
      end
      PHC_MEM_WAIT: begin
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
        exdm_clr = 1'b1;
        dmwb_clr = 1'b1;
        if (!dm_busy) begin
          state_d = PHC_RUN;
        end else if (fault_hit) begin
          state_d = PHC_HALTED;
        end
      end
      PHC_HALTED: begin
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
        exdm_clr = 1'b1;
        dmwb_clr = 1'b1;
        if (resume && !fault_q) begin
          state_d = PHC_RUN;
        end
      end
      default: begin
        state_d = PHC_BOOT;
      end
    endcase
  end

  // State register and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PHC_BOOT;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q || fault_hit;
    end
  end

  assign halted    = (state_q == PHC_HALTED);
  assign mem_fault = fault_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic run_free;
  logic stall_ev;
  logic flush_ev;

  assign run_free = run_q && !halt_wb && !dm_busy;
  assign flush_ev = run_free && branch_taken;
  assign stall_ev = (run_free && !branch_taken && load_use)
                  || (state_q == PHC_MEM_WAIT);

  phc_sat_counter #(
    .W (32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .en_i  (stall_ev),
    .cnt_o (stall_cycles)
  );

  phc_sat_counter #(
    .W (32)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .en_i  (flush_ev),
    .cnt_o (flush_count)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an expected-vector queue.
// Output vector: {pc,ifid_en,stall,ifid_clr,idex_en,idex_clr,exdm_en,exdm_clr,dmwb_en,dmwb_clr,halted,fault}
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use = 1'b0;
  logic branch_taken = 1'b0;
  logic dm_busy = 1'b0;
  logic halt_wb = 1'b0;
  logic resume = 1'b0;
  logic pc_en, ifid_en, ifid_stall, ifid_clr;
  logic idex_en, idex_clr, exdm_en, exdm_clr;
  logic dmwb_en, dmwb_clr, halted, mem_fault;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  localparam logic [11:0] BOOTV = 12'b0000_0000_0000;
  localparam logic [11:0] RUNV  = 12'b1101_1111_1100;
  localparam logic [11:0] FRZ   = 12'b0001_0101_0100;
  localparam logic [11:0] HLT   = 12'b0001_0101_0110;
  localparam logic [11:0] HLTF  = 12'b0001_0101_0111;
  localparam logic [11:0] BRV   = 12'b1100_1011_1100;
  localparam logic [11:0] LUV   = 12'b0111_1011_1100;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LU   = 5'b10000;
  localparam logic [4:0] BR   = 5'b01000;
  localparam logic [4:0] BZ   = 5'b00100;
  localparam logic [4:0] HW   = 5'b00010;
  localparam logic [4:0] RS   = 5'b00001;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (16),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .dm_busy      (dm_busy),
    .halt_wb      (halt_wb),
    .resume       (resume),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_stall   (ifid_stall),
    .ifid_clr     (ifid_clr),
    .idex_en      (idex_en),
    .idex_clr     (idex_clr),
    .exdm_en      (exdm_en),
    .exdm_clr     (exdm_clr),
    .dmwb_en      (dmwb_en),
    .dmwb_clr     (dmwb_clr),
    .halted       (halted),
    .mem_fault    (mem_fault)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expectation, check mid-cycle
  task automatic step(input logic rst, input logic [4:0] in,
                      input logic [11:0] exp, input string tag);
    logic [11:0] obs;
    logic [11:0] want;
    string       t;
    @(posedge clk);
    #1;
    rst_n = rst;
    {load_use, branch_taken, dm_busy, halt_wb, resume} = in;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {pc_en, ifid_en, ifid_stall, ifid_clr, idex_en, idex_clr,
           exdm_en, exdm_clr, dmwb_en, dmwb_clr, halted, mem_fault};
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", t, obs, want);
    end
  endtask

  initial begin
    step(1'b0, NONE, BOOTV, "rst_hold0");
    step(1'b0, NONE, BOOTV, "rst_hold1");
    step(1'b1, NONE, BOOTV, "boot");
    step(1'b1, NONE, RUNV, "run0");
    step(1'b1, NONE, RUNV, "run1");

    step(1'b1, LU, LUV, "load_use");
    step(1'b1, NONE, RUNV, "lu_after");

    step(1'b1, BR | LU, BRV, "br_and_lu");
    step(1'b1, BR, BRV, "branch");
    step(1'b1, NONE, RUNV, "br_after");

    step(1'b1, BZ, FRZ, "busy_c1");
    step(1'b1, BZ, FRZ, "busy_c2");
    step(1'b1, BZ | BR | LU, FRZ, "busy_c3_ign");
    step(1'b1, BZ, FRZ, "busy_c4");
    step(1'b1, BZ, FRZ, "busy_c5");
    step(1'b1, NONE, FRZ, "busy_exit");
    step(1'b1, NONE, RUNV, "busy_run");

`ifdef PIPE_HAZARD_PERF_EN
    vectors++;
    assert (stall_cycles === 32'd6) else begin
      miscompares++;
      $error("FAIL perf_stall: observed %0d expected 6", stall_cycles);
    end
    vectors++;
    assert (flush_count === 32'd2) else begin
      miscompares++;
      $error("FAIL perf_flush: observed %0d expected 2", flush_count);
    end
`endif

    step(1'b1, HW | BZ, FRZ, "halt_wb");
    for (int i = 0; i < 9; i++) begin
      step(1'b1, NONE, HLT, "halted");
    end
    step(1'b1, RS, HLT, "resume_cyc");
    step(1'b1, NONE, RUNV, "resumed");

    for (int i = 0; i < 20; i++) begin
      step(1'b1, BZ, (i < 16) ? FRZ : HLTF, "timeout");
    end
    step(1'b1, RS, HLTF, "resume_ign");
    step(1'b1, NONE, HLTF, "fault_hold");

    step(1'b0, NONE, BOOTV, "rst_fault");
    step(1'b1, NONE, BOOTV, "boot2");
    step(1'b1, NONE, RUNV, "run_clean");

    step(1'b1, HW, FRZ, "halt_wb2");
    step(1'b1, NONE, HLT, "halted2a");
    step(1'b1, NONE, HLT, "halted2b");
    step(1'b1, NONE, HLT, "halted2c");
    step(1'b0, RS, BOOTV, "rst_halted");
    step(1'b1, NONE, BOOTV, "boot3");
    step(1'b1, NONE, RUNV, "run_final");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
